// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder/subtractor family:
// slice width, stage-count and field-offset helpers, and the per-slice G/P struct.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
  } cla_gp_t;

  function automatic int nstg_of(input int width);
    return (width < SLICE_W) ? 1 : width / SLICE_W;
  endfunction

  // Bit offset of stage stg's remaining-subtrahend field in the packed store;
  // stage k keeps width - SLICE_W*(k+1) bits, so the fields shrink down the pipe.
  function automatic int brem_off(input int width, input int stg);
    return stg * width - (SLICE_W * stg * (stg + 1)) / 2;
  endfunction

endpackage

// File: rtl/cla_pipe_sub_if.sv
// Operand/result handshake bundle for cla_pipe_sub.
// CLA_SUB_ADD_MODE_EN adds the per-operation mode bit.
interface cla_pipe_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef CLA_SUB_ADD_MODE_EN
  logic             mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef CLA_SUB_ADD_MODE_EN
    output mode,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef CLA_SUB_ADD_MODE_EN
    input  mode,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: s = x + y + ci, co = carry out.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  cla_gp_t          gp;
  logic [SLICE_W:0] c;

  assign gp.g = x & y;
  assign gp.p = x ^ y;

  assign c[0] = ci;
  assign c[1] = gp.g[0] | (gp.p[0] & ci);
  assign c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & ci);
  assign c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
              | (gp.p[2] & gp.p[1] & gp.p[0] & ci);
  assign c[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
              | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
              | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & ci);

  assign s  = gp.p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_pipe_sub.sv
// Pipelined unsigned subtractor diff = a - b - bin, one CLA slice per stage,
// valid/ready with full backpressure. CLA_SUB_ADD_MODE_EN adds an add mode.
module cla_pipe_sub
  import cla_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NSTG  = nstg_of(WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  cla_pipe_sub_if.slave bus
);

  localparam int BREM_W = (NSTG > 1) ? brem_off(WIDTH, NSTG - 1) : 1;

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("cla_pipe_sub: WIDTH must be a positive multiple of 4");
  end

  logic [NSTG-1:0]            v_reg, v_next, adv, src_v, load;
  logic [NSTG-1:0]            c_reg, c_next;
  logic [NSTG-1:0][WIDTH-1:0] w_reg, w_next;
  logic [BREM_W-1:0]          brem_reg, brem_next;
  logic                       ready_en_reg;
`ifdef CLA_SUB_ADD_MODE_EN
  logic [NSTG-1:0]            m_reg, m_next;
`endif

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv           = '0;
    adv[NSTG-1]   = ~v_reg[NSTG-1] | bus.out_ready;
    for (int i = NSTG - 2; i >= 0; i--) begin
      adv[i] = ~v_reg[i] | adv[i+1];
    end
  end

  assign bus.in_ready = ready_en_reg & adv[0];

  if (NSTG == 1) begin : g_no_brem
    assign brem_next = brem_reg;
  end

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    localparam int LO   = gi * SLICE_W;
    localparam int DONE = LO + SLICE_W;
    localparam int BO   = brem_off(WIDTH, gi);

    logic [WIDTH-1:0]   word_w, w_upd;
    logic [SLICE_W-1:0] bnib_w, y_w, s_w;
    logic               ci_w, co_w;
`ifdef CLA_SUB_ADD_MODE_EN
    logic               m_w;
`endif

    if (gi == 0) begin : g_head
      assign word_w   = bus.a;
      assign bnib_w   = bus.b[SLICE_W-1:0];
      assign src_v[0] = bus.in_valid & bus.in_ready;
`ifdef CLA_SUB_ADD_MODE_EN
      assign m_w      = bus.mode;
      assign ci_w     = bus.mode ? bus.bin : ~bus.bin;
`else
      assign ci_w     = ~bus.bin;
`endif
      if (NSTG > 1) begin : g_brem
        assign brem_next[BO +: WIDTH-DONE] = load[0] ? bus.b[WIDTH-1:DONE]
                                                     : brem_reg[BO +: WIDTH-DONE];
      end
    end else begin : g_body
      localparam int PBO = brem_off(WIDTH, gi - 1);
      assign word_w    = w_reg[gi-1];
      assign bnib_w    = brem_reg[PBO +: SLICE_W];
      assign src_v[gi] = v_reg[gi-1];
      assign ci_w      = c_reg[gi-1];
`ifdef CLA_SUB_ADD_MODE_EN
      assign m_w       = m_reg[gi-1];
`endif
      if (gi < NSTG - 1) begin : g_brem
        assign brem_next[BO +: WIDTH-DONE] = load[gi] ? brem_reg[PBO+SLICE_W +: WIDTH-DONE]
                                                      : brem_reg[BO +: WIDTH-DONE];
      end
    end

`ifdef CLA_SUB_ADD_MODE_EN
    assign y_w = m_w ? bnib_w : ~bnib_w;
`else
    assign y_w = ~bnib_w;
`endif

    cla4_slice u_slice (
      .x  (word_w[LO +: SLICE_W]),
      .y  (y_w),
      .ci (ci_w),
      .s  (s_w),
      .co (co_w)
    );

    // Result nibbles overwrite the consumed minuend nibbles in the same word.
    always_comb begin
      w_upd                 = word_w;
      w_upd[LO +: SLICE_W]  = s_w;
    end

    // Data only loads when a valid operation enters; empty stages hold still.
    assign load[gi]   = adv[gi] & src_v[gi];
    assign v_next[gi] = adv[gi] ? src_v[gi] : v_reg[gi];
    assign w_next[gi] = load[gi] ? w_upd : w_reg[gi];
    assign c_next[gi] = load[gi] ? co_w : c_reg[gi];
`ifdef CLA_SUB_ADD_MODE_EN
    assign m_next[gi] = load[gi] ? m_w : m_reg[gi];
`endif
  end

  // Carries reset to 1 so the idle borrow output reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg        <= '0;
      c_reg        <= '1;
      w_reg        <= '0;
      brem_reg     <= '0;
      ready_en_reg <= 1'b0;
`ifdef CLA_SUB_ADD_MODE_EN
      m_reg        <= '0;
`endif
    end else begin
      v_reg        <= v_next;
      c_reg        <= c_next;
      w_reg        <= w_next;
      brem_reg     <= brem_next;
      ready_en_reg <= 1'b1;
`ifdef CLA_SUB_ADD_MODE_EN
      m_reg        <= m_next;
`endif
    end
  end

  assign bus.out_valid = v_reg[NSTG-1];
  assign bus.diff      = w_reg[NSTG-1];
`ifdef CLA_SUB_ADD_MODE_EN
  assign bus.bout      = m_reg[NSTG-1] ? c_reg[NSTG-1] : ~c_reg[NSTG-1];
`else
  assign bus.bout      = ~c_reg[NSTG-1];
`endif

endmodule
